mini_unpack_fsm: RTL and testbench
==================================

Name: mini_unpack_fsm

Overview:
Reverse path of the mini FSM/RAM datapath. On a start pulse it reads N_WORDS packed words from a synchronous-read word RAM. It splits each word into two bytes and writes them in order into a byte-wide RAM through a write port. It signals completion with a one-cycle done pulse.

Parameters:
N_WORDS, 2, number of packed words to unpack (at least 1)
DATA_W, 8, byte width; the packed word is 2*DATA_W bits
WORD_AW, derived as max(1, clog2(N_WORDS)), word address width (localparam)
BYTE_AW, derived as WORD_AW+1, byte address width (localparam)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin unpacking; sampled only in IDLE
ram_in_re  out  1  read strobe to the word RAM
ram_in_addr_rd  out  WORD_AW  word read address
ram_in_data_rd  in  2*DATA_W  word read data; valid the cycle after ram_in_re
ram_out_we  out  1  byte write strobe
ram_out_addr_wr  out  BYTE_AW  byte write address
ram_out_data_wr  out  DATA_W  byte write data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. While rst=1:
  - state goes to IDLE;
  - word index widx=0, word_q=0;
  - all outputs are 0 immediately, without waiting for a clock edge.
- State encoding (3 bits): IDLE, READ, LATCH, WR_LO, WR_HI, DONE.
- Outputs are decoded from the state register (Moore). Every address and data output is 0 in any state where its strobe is low.
- IDLE: no strobes asserted. start=1 at a posedge moves to READ.
- READ: ram_in_re=1, ram_in_addr_rd=widx. Next state is LATCH.
- LATCH: word_q <= ram_in_data_rd (captured at the end of this cycle). Next state is WR_LO.
- WR_LO: ram_out_we=1, ram_out_addr_wr={widx,1'b0}, ram_out_data_wr=word_q[DATA_W-1:0]. Next state is WR_HI.
- WR_HI: ram_out_we=1, ram_out_addr_wr={widx,1'b1}, ram_out_data_wr=word_q[2*DATA_W-1:DATA_W].
  - If widx==N_WORDS-1: widx<=0, next state DONE.
  - Otherwise: widx<=widx+1, next state READ.
- DONE: done=1 for exactly one cycle. Next state is IDLE.
- Byte order: the low half of a word goes to the even byte address, the high half to the odd one.
- Latency: with start sampled at edge E0, READ occupies the cycle after E0.
  - Each word takes 4 cycles.
  - done is high in cycle 4*N_WORDS+1 after E0 (cycle 9 for N_WORDS=2).
- start outside IDLE, including during DONE, is ignored. It is not queued.
- If start is held high continuously, a new run begins at the first posedge in IDLE. Consecutive runs are separated by exactly one IDLE cycle.
- Reset mid-run aborts immediately. Writes already issued stay in the byte RAM. No done pulse is generated.
- widx wraps only through the explicit clear in WR_HI; it never overflows.
- Addresses increment strictly. Each byte address is written exactly once per run.

Decomposition:
- Shared package mini_pkg holds:
  - the state encoding localparams (IDLE=0, READ=1, LATCH=2, WR_LO=3, WR_HI=4, DONE=5), shared with the packing FSM;
  - a clog2 constant function.
- No RTL sub-module: the block is a single FSM plus a counter and a word register.
- The bench supplies a behavioural 1-cycle-latency synchronous word RAM model, mini_word_ram.

Test Plan:
1. N_WORDS=2, word RAM [0]=0xA55A, [1]=0x1234; pulse start → byte writes (addr,data) (0,0x5A), (1,0xA5), (2,0x34), (3,0x12) in consecutive WR cycles; done high exactly in cycle 9 after the start edge; busy high in cycles 1–9.
2. Start pulsed again during WR_LO of word 0 → ignored: exactly 4 writes, a single done pulse, then IDLE.
3. Assert rst asynchronously mid-run (between clock edges, in WR_HI of word 0) → ram_out_we, busy and done drop to 0 before the next edge; after release, a new start produces the full 4-write sequence from address 0.
4. Start held high continuously for two runs with RAM contents 0xFF00, 0x00FF → writes 0x00, 0xFF, 0xFF, 0x00 repeated; exactly one IDLE cycle between the done pulse and the next READ.
5. N_WORDS=4, words 0x0100, 0x0302, 0x0504, 0x0706 → byte RAM addresses 0..7 receive 0x00..0x07; done at cycle 17 after the start edge.

Source files
------------

// File: rtl/mini_unpack_fsm_pkg.sv
// Shared definitions for the mini FSM/RAM datapath (pack and unpack paths).
// Holds the common 3-bit state encoding and a constant clog2 helper.
package mini_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_WR_LO = 3'd3;
  localparam logic [2:0] S_WR_HI = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    READ  = S_READ,
    LATCH = S_LATCH,
    WR_LO = S_WR_LO,
    WR_HI = S_WR_HI,
    DONE  = S_DONE
  } state_t;

  // Ceiling log2 for elaboration-time width computation.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'sd1 <<< res) < value) begin
        res = res + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mini_unpack_fsm.sv
// Unpacker: reads N_WORDS packed words from a synchronous-read word RAM and
// writes each as two bytes (low half to even address, high half to odd
// address) into a byte RAM, then pulses done for one cycle.
// All outputs are registered and computed for the state being entered, so
// they behave as a Moore decode of the state register.
module mini_unpack_fsm
  import mini_pkg::*;
#(
  parameter  int N_WORDS = 2,
  parameter  int DATA_W  = 8,
  localparam int WORD_AW = (clog2(N_WORDS) > 1) ? clog2(N_WORDS) : 1,
  localparam int BYTE_AW = WORD_AW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                ram_in_re,
  output logic [WORD_AW-1:0]  ram_in_addr_rd,
  input  logic [2*DATA_W-1:0] ram_in_data_rd,
  output logic                ram_out_we,
  output logic [BYTE_AW-1:0]  ram_out_addr_wr,
  output logic [DATA_W-1:0]   ram_out_data_wr,
  output logic                busy,
  output logic                done
);

  localparam logic [WORD_AW-1:0] LAST_IDX = WORD_AW'(N_WORDS - 1);

  state_t              state_r;
  logic [WORD_AW-1:0]  widx_r;
  // Only the high half of the latched word must be held: the low half is
  // forwarded straight from the read data into the WR_LO output register.
  logic [DATA_W-1:0]   word_hi_r;

  // State register, word counter, word latch and registered output decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      widx_r          <= '0;
      word_hi_r       <= '0;
      ram_in_re       <= 1'b0;
      ram_in_addr_rd  <= '0;
      ram_out_we      <= 1'b0;
      ram_out_addr_wr <= '0;
      ram_out_data_wr <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      // Strobes, addresses and data default low; each arm raises the ones
      // belonging to the state it moves into.
      ram_in_re       <= 1'b0;
      ram_in_addr_rd  <= '0;
      ram_out_we      <= 1'b0;
      ram_out_addr_wr <= '0;
      ram_out_data_wr <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r        <= READ;
            ram_in_re      <= 1'b1;
            ram_in_addr_rd <= widx_r;
            busy           <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          state_r <= LATCH;
          busy    <= 1'b1;
        end
        LATCH: begin
          word_hi_r       <= ram_in_data_rd[2*DATA_W-1:DATA_W];
          state_r         <= WR_LO;
          ram_out_we      <= 1'b1;
          ram_out_addr_wr <= {widx_r, 1'b0};
          ram_out_data_wr <= ram_in_data_rd[DATA_W-1:0];
          busy            <= 1'b1;
        end
        WR_LO: begin
          state_r         <= WR_HI;
          ram_out_we      <= 1'b1;
          ram_out_addr_wr <= {widx_r, 1'b1};
          ram_out_data_wr <= word_hi_r;
          busy            <= 1'b1;
        end
        WR_HI: begin
          busy <= 1'b1;
          if (widx_r == LAST_IDX) begin
            widx_r  <= '0;
            state_r <= DONE;
            done    <= 1'b1;
          end else begin
            widx_r         <= widx_r + {{(WORD_AW-1){1'b0}}, 1'b1};
            state_r        <= READ;
            ram_in_re      <= 1'b1;
            ram_in_addr_rd <= widx_r + {{(WORD_AW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          widx_r  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mini_unpack_fsm.sv
// Self-checking bench for mini_unpack_fsm: one instance with N_WORDS=2 and
// one with N_WORDS=4, each fed by a 1-cycle-latency word RAM model.
// Expected byte writes (address, data, cycle) are queued when a run starts
// and popped as the DUT issues them.
module tb_mini_unpack_fsm;

  typedef struct {
    int          addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  logic        clk;
  logic        rst;

  logic        start_a, re_a, we_a, busy_a, done_a;
  logic [0:0]  raddr_a;
  logic [15:0] rdata_a;
  logic [1:0]  waddr_a;
  logic [7:0]  wdata_a;

  logic        start_b, re_b, we_b, busy_b, done_b;
  logic [1:0]  raddr_b;
  logic [15:0] rdata_b;
  logic [2:0]  waddr_b;
  logic [7:0]  wdata_b;

  logic [15:0] mem_a [0:1];
  logic [15:0] mem_b [0:3];

  wr_t q_a[$];
  wr_t q_b[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_cnt_a = 0, wr_cnt_b = 0;
  int done_cnt_a = 0, done_cnt_b = 0;

  mini_unpack_fsm #(.N_WORDS(2), .DATA_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .ram_in_re(re_a), .ram_in_addr_rd(raddr_a), .ram_in_data_rd(rdata_a),
    .ram_out_we(we_a), .ram_out_addr_wr(waddr_a), .ram_out_data_wr(wdata_a),
    .busy(busy_a), .done(done_a)
  );

  mini_unpack_fsm #(.N_WORDS(4), .DATA_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .ram_in_re(re_b), .ram_in_addr_rd(raddr_b), .ram_in_data_rd(rdata_b),
    .ram_out_we(we_b), .ram_out_addr_wr(waddr_b), .ram_out_data_wr(wdata_b),
    .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mini_word_ram: synchronous read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (re_a) rdata_a <= mem_a[raddr_a];
    if (re_b) rdata_b <= mem_b[raddr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_a(input int offset);
    for (int w = 0; w < 2; w++) begin
      q_a.push_back('{2*w,     mem_a[w][7:0],  3 + 4*w + offset});
      q_a.push_back('{2*w + 1, mem_a[w][15:8], 4 + 4*w + offset});
    end
  endtask

  task automatic push_b(input int offset);
    for (int w = 0; w < 4; w++) begin
      q_b.push_back('{2*w,     mem_b[w][7:0],  3 + 4*w + offset});
      q_b.push_back('{2*w + 1, mem_b[w][15:8], 4 + 4*w + offset});
    end
  endtask

  // Advance to the next falling edge and score any write / done seen there.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc++;
    if (we_a) begin
      wr_cnt_a++;
      chk("wr_a_expected", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        chk("wr_a_addr", 32'(waddr_a), 32'(e.addr));
        chk("wr_a_data", 32'(wdata_a), 32'(e.data));
        chk("wr_a_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (we_b) begin
      wr_cnt_b++;
      chk("wr_b_expected", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        chk("wr_b_addr", 32'(waddr_b), 32'(e.addr));
        chk("wr_b_data", 32'(wdata_b), 32'(e.data));
        chk("wr_b_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  endtask

  task automatic clr_a();
    cyc = 0;
    wr_cnt_a = 0;
    done_cnt_a = 0;
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    mem_a[0] = 16'h0000; mem_a[1] = 16'h0000;
    for (int i = 0; i < 4; i++) mem_b[i] = 16'h0000;

    // Reset state
    tick(); tick();
    chk("rst_re_a",   32'(re_a),    32'd0);
    chk("rst_raddr_a", 32'(raddr_a), 32'd0);
    chk("rst_we_a",   32'(we_a),    32'd0);
    chk("rst_waddr_a", 32'(waddr_a), 32'd0);
    chk("rst_wdata_a", 32'(wdata_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a),  32'd0);
    chk("rst_done_a", 32'(done_a),  32'd0);
    chk("rst_busy_b", 32'(busy_b),  32'd0);
    chk("rst_we_b",   32'(we_b),    32'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy_a", 32'(busy_a), 32'd0);

    // 1: basic two-word run, latency and busy window
    mem_a[0] = 16'hA55A; mem_a[1] = 16'h1234;
    clr_a(); push_a(0);
    start_a = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) begin
        start_a = 1'b0;
        chk("t1_re", 32'(re_a), 32'd1);
        chk("t1_raddr", 32'(raddr_a), 32'd0);
      end
      chk("t1_busy", 32'(busy_a), 32'(i <= 9));
      chk("t1_done", 32'(done_a), 32'(i == 9));
    end
    chk("t1_wr_count", 32'(wr_cnt_a), 32'd4);
    chk("t1_done_count", 32'(done_cnt_a), 32'd1);
    chk("t1_queue_empty", 32'(q_a.size()), 32'd0);

    // 2: start re-pulsed during WR_LO of word 0 is ignored
    clr_a(); push_a(0);
    start_a = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      start_a = (i == 3);
      chk("t2_done", 32'(done_a), 32'(i == 9));
    end
    chk("t2_wr_count", 32'(wr_cnt_a), 32'd4);
    chk("t2_done_count", 32'(done_cnt_a), 32'd1);
    chk("t2_idle_busy", 32'(busy_a), 32'd0);
    chk("t2_idle_re", 32'(re_a), 32'd0);

    // 3: asynchronous reset in WR_HI of word 0, then a clean rerun
    mem_a[0] = 16'hBEEF; mem_a[1] = 16'hC0DE;
    clr_a(); push_a(0);
    start_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) start_a = 1'b0;
    end
    chk("t3_in_wr_hi", 32'(we_a), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t3_async_we", 32'(we_a), 32'd0);
    chk("t3_async_busy", 32'(busy_a), 32'd0);
    chk("t3_async_done", 32'(done_a), 32'd0);
    chk("t3_async_waddr", 32'(waddr_a), 32'd0);
    tick();
    chk("t3_partial_wr", 32'(wr_cnt_a), 32'd2);
    q_a.delete();
    rst = 1'b0;
    tick();
    chk("t3_no_done", 32'(done_cnt_a), 32'd0);
    chk("t3_idle_busy", 32'(busy_a), 32'd0);
    clr_a(); push_a(0);
    start_a = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) start_a = 1'b0;
      chk("t3_done", 32'(done_a), 32'(i == 9));
    end
    chk("t3_wr_count", 32'(wr_cnt_a), 32'd4);
    chk("t3_queue_empty", 32'(q_a.size()), 32'd0);

    // 4: start held high across two back-to-back runs
    mem_a[0] = 16'hFF00; mem_a[1] = 16'h00FF;
    clr_a(); push_a(0); push_a(10);
    start_a = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i == 19) start_a = 1'b0;
      chk("t4_done", 32'(done_a), 32'((i == 9) || (i == 19)));
      if (i == 10) begin
        chk("t4_gap_busy", 32'(busy_a), 32'd0);
        chk("t4_gap_re", 32'(re_a), 32'd0);
      end
      if (i == 11) chk("t4_second_read", 32'(re_a), 32'd1);
    end
    chk("t4_wr_count", 32'(wr_cnt_a), 32'd8);
    chk("t4_done_count", 32'(done_cnt_a), 32'd2);
    chk("t4_queue_empty", 32'(q_a.size()), 32'd0);
    chk("t4_idle_busy", 32'(busy_a), 32'd0);

    // 5: four-word instance
    mem_b[0] = 16'h0100; mem_b[1] = 16'h0302;
    mem_b[2] = 16'h0504; mem_b[3] = 16'h0706;
    cyc = 0; wr_cnt_b = 0; done_cnt_b = 0;
    push_b(0);
    start_b = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) start_b = 1'b0;
      chk("t5_busy", 32'(busy_b), 32'(i <= 17));
      chk("t5_done", 32'(done_b), 32'(i == 17));
    end
    chk("t5_wr_count", 32'(wr_cnt_b), 32'd8);
    chk("t5_done_count", 32'(done_cnt_b), 32'd1);
    chk("t5_queue_empty", 32'(q_b.size()), 32'd0);
    chk("t5_a_untouched", 32'(wr_cnt_a), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
